// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and sequencer that puts two requesters
// (A = instruction fetch, B = load/store) in front of one cache/RAM port.
// The granted transaction is held stable on mem_* until the cache reports
// done on mem_state. Read data then comes back with a one-cycle ack.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   a_req/a_wr/a_addr/a_data, a_ack   requester A; req is held until ack
//   b_req/b_wr/b_addr/b_data, b_ack   requester B, same protocol
//   rsp_q, rsp_err                    read data / timeout flag, valid with ack
//   mem_addr/mem_data/mem_wr          registered cache inputs
//   mem_state, mem_miss, mem_q        cache done, miss flag, read data
//   miss_cnt, cnt_clr                 saturating read-miss counter and its clear
//   busy                              high whenever not IDLE
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_wr,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ack,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ack,
  output logic [DW-1:0] rsp_q,
  output logic          rsp_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wr,
  input  logic          mem_state,
  input  logic          mem_miss,
  input  logic [DW-1:0] mem_q,
  output logic [CW-1:0] miss_cnt,
  input  logic          cnt_clr,
  output logic          busy
);

  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic [WCW-1:0]   wait_cnt, wait_cnt_nxt;
  logic             a_ack_nxt, b_ack_nxt;
  logic [DW-1:0]    rsp_q_nxt;
  logic             rsp_err_nxt;
  logic [AW-1:0]    mem_addr_nxt;
  logic [DW-1:0]    mem_data_nxt;
  logic             mem_wr_nxt;
  logic [CW-1:0]    miss_cnt_nxt;
  logic             busy_nxt;
  logic             pick_b;
  logic             miss_inc;

  // State and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_B;
      wait_cnt   <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      rsp_q      <= '0;
      rsp_err    <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wr     <= 1'b0;
      miss_cnt   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      wait_cnt   <= wait_cnt_nxt;
      a_ack      <= a_ack_nxt;
      b_ack      <= b_ack_nxt;
      rsp_q      <= rsp_q_nxt;
      rsp_err    <= rsp_err_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_data   <= mem_data_nxt;
      mem_wr     <= mem_wr_nxt;
      miss_cnt   <= miss_cnt_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    wait_cnt_nxt   = wait_cnt;
    a_ack_nxt      = 1'b0;
    b_ack_nxt      = 1'b0;
    rsp_q_nxt      = rsp_q;
    rsp_err_nxt    = rsp_err;
    mem_addr_nxt   = mem_addr;
    mem_data_nxt   = mem_data;
    mem_wr_nxt     = mem_wr;
    miss_cnt_nxt   = miss_cnt;
    miss_inc       = 1'b0;
    // B wins when it is alone, or on a tie when A was served last
    pick_b         = b_req && (!a_req || (last_grant == GNT_A));

    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          last_grant_nxt = pick_b;
          mem_wr_nxt     = pick_b ? b_wr   : a_wr;
          mem_addr_nxt   = pick_b ? b_addr : a_addr;
          mem_data_nxt   = pick_b ? b_data : a_data;
          state_nxt      = ISSUE;
        end
      end

      // Cache has not seen the new inputs yet, so mem_state is stale here
      ISSUE: begin
        wait_cnt_nxt = '0;
        state_nxt    = WAIT;
      end

      WAIT: begin
        if (mem_state) begin
          if (!mem_wr) begin
            rsp_q_nxt = mem_q;
          end
          rsp_err_nxt = 1'b0;
          miss_inc    = !mem_wr && mem_miss;
          a_ack_nxt   = (last_grant == GNT_A);
          b_ack_nxt   = (last_grant == GNT_B);
          state_nxt   = RESP;
        end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
          rsp_err_nxt = 1'b1;
          a_ack_nxt   = (last_grant == GNT_A);
          b_ack_nxt   = (last_grant == GNT_B);
          state_nxt   = RESP;
        end else begin
          wait_cnt_nxt = wait_cnt + WCW'(1);
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Clear has priority over a coincident increment
    if (cnt_clr) begin
      miss_cnt_nxt = '0;
    end else if (miss_inc && (miss_cnt != '1)) begin
      miss_cnt_nxt = miss_cnt + CW'(1);
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (CW=4 to reach saturation).
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_wr, b_req, b_wr;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ack, b_ack;
  logic [DW-1:0] rsp_q;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wr;
  logic          mem_state, mem_miss;
  logic [DW-1:0] mem_q;
  logic [CW-1:0] miss_cnt;
  logic          cnt_clr;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int lat;

  mem_arbiter #(.AW(AW), .DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .rsp_q(rsp_q), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
    .mem_state(mem_state), .mem_miss(mem_miss), .mem_q(mem_q),
    .miss_cnt(miss_cnt), .cnt_clr(cnt_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction from IDLE; returns negedges from request to ack
  task automatic run_txn(input bit port_b, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, output int l);
    if (port_b) begin
      b_req = 1'b1; b_wr = wr; b_addr = addr; b_data = data;
    end else begin
      a_req = 1'b1; a_wr = wr; a_addr = addr; a_data = data;
    end
    l = 0;
    do begin
      tick();
      l++;
    end while (!(port_b ? b_ack : a_ack) && l < 200);
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_req = 0; a_wr = 0; a_addr = '0; a_data = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_data = '0;
    mem_state = 1'b1; mem_miss = 0; mem_q = '0; cnt_clr = 0;

    // Reset values
    tick();
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_rsp_q", rsp_q, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // T1: single A read miss, done in first WAIT cycle
    a_req = 1; a_wr = 0; a_addr = 32'h10;
    mem_q = 32'hDEADBEEF; mem_miss = 1;
    tick();
    chk("t1_issue_addr", mem_addr, 32'h10);
    chk("t1_issue_wr", mem_wr, 0);
    chk("t1_busy", busy, 1);
    chk("t1_no_ack_issue", a_ack, 0);
    tick();
    chk("t1_no_ack_wait", a_ack, 0);
    tick();
    chk("t1_a_ack", a_ack, 1);
    chk("t1_b_ack", b_ack, 0);
    chk("t1_rsp_q", rsp_q, 32'hDEADBEEF);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_miss_cnt", miss_cnt, 1);
    a_req = 0;
    tick();
    chk("t1_ack_pulse", a_ack, 0);
    chk("t1_idle_busy", busy, 0);

    // T2: tie out of reset, A write vs B read
    rst = 1; tick(); rst = 0;
    a_req = 1; a_wr = 1; a_addr = 32'h4; a_data = 32'h55;
    b_req = 1; b_wr = 0; b_addr = 32'h8; b_data = 32'h99;
    mem_q = 32'h12345678; mem_miss = 0;
    tick();
    chk("t2_a_wr", mem_wr, 1);
    chk("t2_a_addr", mem_addr, 32'h4);
    chk("t2_a_data", mem_data, 32'h55);
    tick();
    tick();
    chk("t2_a_ack", a_ack, 1);
    chk("t2_b_ack_low", b_ack, 0);
    chk("t2_wr_rsp_q_held", rsp_q, 0);
    a_req = 0;
    tick();
    chk("t2_a_ack_pulse", a_ack, 0);
    tick();
    chk("t2_b_addr", mem_addr, 32'h8);
    chk("t2_b_wr", mem_wr, 0);
    chk("t2_b_data", mem_data, 32'h99);
    tick();
    tick();
    chk("t2_b_ack", b_ack, 1);
    chk("t2_a_ack_low", a_ack, 0);
    chk("t2_b_rsp_q", rsp_q, 32'h12345678);
    b_req = 0;
    tick();
    chk("t2_b_ack_pulse", b_ack, 0);

    // T3: both requesting continuously, strict alternation starting with A
    a_req = 1; a_wr = 0; a_addr = 32'h100;
    b_req = 1; b_wr = 0; b_addr = 32'h200;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_issue_addr", mem_addr, (i % 2 == 1) ? 32'h200 : 32'h100);
      tick();
      chk("t3_wait_addr", mem_addr, (i % 2 == 1) ? 32'h200 : 32'h100);
      tick();
      chk("t3_a_ack", a_ack, (i % 2 == 1) ? 1'b0 : 1'b1);
      chk("t3_b_ack", b_ack, (i % 2 == 1) ? 1'b1 : 1'b0);
      tick();
    end
    a_req = 0; b_req = 0;

    // T4: timeout after 64 WAIT cycles, then a normal read clears rsp_err
    mem_state = 0; mem_q = 32'hBAD0BAD0;
    a_req = 1; a_wr = 0; a_addr = 32'h40;
    tick();
    tick();
    lat = 0;
    while (a_ack !== 1'b1 && lat < 200) begin
      lat++;
      tick();
    end
    chk("t4_timeout_wait_cycles", lat, 64);
    chk("t4_a_ack", a_ack, 1);
    chk("t4_rsp_err", rsp_err, 1);
    chk("t4_rsp_q_held", rsp_q, 32'h12345678);
    a_req = 0;
    tick();
    mem_state = 1; mem_q = 32'hCAFE0001;
    run_txn(0, 0, 32'h44, 32'h0, lat);
    chk("t4_normal_latency", lat, 3);
    chk("t4_rsp_err_cleared", rsp_err, 0);
    chk("t4_rsp_q", rsp_q, 32'hCAFE0001);

    // T5: reset during WAIT of a B read
    mem_state = 0;
    b_req = 1; b_wr = 0; b_addr = 32'h80;
    tick();
    tick();
    tick();
    chk("t5_wait_addr", mem_addr, 32'h80);
    rst = 1;
    a_req = 1; a_wr = 1; a_addr = 32'h300; a_data = 32'h77;
    #1;
    chk("t5_rst_mem_addr", mem_addr, 0);
    chk("t5_rst_mem_data", mem_data, 0);
    chk("t5_rst_mem_wr", mem_wr, 0);
    chk("t5_rst_rsp_q", rsp_q, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_b_ack", b_ack, 0);
    chk("t5_rst_miss_cnt", miss_cnt, 0);
    tick();
    chk("t5_no_b_ack", b_ack, 0);
    rst = 0;
    mem_state = 1;
    tick();
    chk("t5_tie_a_addr", mem_addr, 32'h300);
    chk("t5_tie_a_wr", mem_wr, 1);
    tick();
    tick();
    chk("t5_a_ack", a_ack, 1);
    chk("t5_b_ack_low", b_ack, 0);
    a_req = 0; b_req = 0;
    tick();
    chk("t5_idle", busy, 0);

    // T6: saturation, writes ignored, clear and clear-vs-increment
    mem_miss = 1;
    for (int i = 0; i < 15; i++) begin
      run_txn(0, 0, 32'h1000 + 32'(i), 32'h0, lat);
    end
    chk("t6_cnt_15", miss_cnt, 15);
    run_txn(0, 0, 32'h2000, 32'h0, lat);
    chk("t6_cnt_saturated", miss_cnt, 15);
    run_txn(1, 1, 32'h2004, 32'h5, lat);
    chk("t6_write_no_inc", miss_cnt, 15);
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    chk("t6_clear", miss_cnt, 0);
    run_txn(0, 0, 32'h2008, 32'h0, lat);
    chk("t6_cnt_1", miss_cnt, 1);
    a_req = 1; a_wr = 0; a_addr = 32'h200C;
    tick();
    tick();
    cnt_clr = 1;
    tick();
    chk("t6_clr_ack", a_ack, 1);
    chk("t6_clr_wins", miss_cnt, 0);
    cnt_clr = 0;
    a_req = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single cache/RAM port (data, addr, wr, state, is_missrate, q).
- Grants the port round-robin and holds the cache inputs stable for the whole transaction.
- Waits for the cache's done signal (state), returns read data with a one-cycle acknowledge, and counts read misses.
- Sits between the instruction-fetch requester (port A) and the load/store requester (port B).

Parameters:
AW, 32, address width
DW, 32, data width
CW, 16, miss counter width
TIMEOUT, 64, max WAIT cycles before a transaction is aborted with error

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
a_req  in  1  port A request, held until a_ack
a_wr  in  1  port A write (1) / read (0)
a_addr  in  AW  port A address
a_data  in  DW  port A write data
a_ack  out  1  port A one-cycle completion pulse
b_req, b_wr, b_addr, b_data  in  1/1/AW/DW  port B, same meaning as port A
b_ack  out  1  port B one-cycle completion pulse
rsp_q  out  DW  read data, valid while a_ack or b_ack is high
rsp_err  out  1  timeout flag, valid while a_ack or b_ack is high
mem_addr  out  AW  to cache addr, registered
mem_data  out  DW  to cache data, registered
mem_wr  out  1  to cache wr, registered
mem_state  in  1  cache done (1 = transaction complete)
mem_miss  in  1  cache is_missrate
mem_q  in  DW  cache q
miss_cnt  out  CW  saturating count of read misses
cnt_clr  in  1  synchronous clear of miss_cnt
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous): state=IDLE; a_ack, b_ack, rsp_err, busy = 0; rsp_q, mem_addr, mem_data, mem_wr, miss_cnt = 0; last_grant=B, so A wins the first tie; wait counter = 0. A reset in any state aborts the transaction and issues no ack.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant the port that is not last_grant.
  - On grant: latch that port's wr/addr/data into mem_*, update last_grant, go to ISSUE.
- ISSUE: one cycle. mem_state is ignored here because the cache has not yet seen the new inputs and its state output is stale. Clear the wait counter and go to WAIT.
- WAIT:
  - Each cycle with mem_state=0: increment the wait counter.
  - mem_state=1: capture mem_q into rsp_q (reads only; rsp_q holds its old value on writes) and set rsp_err=0.
    - If read and mem_miss=1: increment miss_cnt, saturating at all-ones.
    - Go to RESP.
  - Counter reaches TIMEOUT-1 with mem_state still 0: rsp_err=1, rsp_q unchanged, go to RESP.
- RESP: assert the granted port's ack for exactly one cycle, then return to IDLE. Latency from request seen in IDLE to ack is 3 cycles minimum (IDLE, ISSUE, WAIT, then ack in RESP).
- mem_* hold their last value between transactions. They never return to 0, so the cache sees no spurious input change.
- Back-to-back transactions:
  - A requester keeping req high after ack starts a new transaction. It is arbitrated again in the next IDLE cycle.
  - With both ports requesting continuously, grants strictly alternate A, B, A, ...
  - Two identical consecutive transactions are legal. The cache does not re-run them, and its state returns 1 in WAIT.
- A requester dropping req, or changing its inputs, before ack is a protocol violation. The latched transaction still completes and still acks.
- rsp_err is cleared at the next completion without timeout.
- cnt_clr:
  - Clears miss_cnt on the next edge.
  - If it coincides with an increment, the clear wins and miss_cnt=0.
  - Writes never increment miss_cnt, even if mem_miss=1.

Test Plan:
- Single A read, addr=0x10, mem_state rises in the first WAIT cycle, mem_q=0xDEADBEEF, mem_miss=1 -> a_ack pulses 3 cycles after a_req, rsp_q=0xDEADBEEF, rsp_err=0, miss_cnt=1, b_ack stays 0.
- A and B both request at once out of reset (A write addr=4 data=0x55, B read addr=8) -> A granted first (mem_wr=1, mem_addr=4); B is issued only after a_ack; each ack is exactly one cycle.
- Both ports hold req high for 6 transactions -> grant order A,B,A,B,A,B; mem_* stable through each ISSUE/WAIT.
- mem_state held 0 with TIMEOUT=64 -> ack exactly 64 WAIT cycles after ISSUE with rsp_err=1; the next normal transaction returns rsp_err=0.
- Assert rst during WAIT of a B read -> all outputs 0 immediately, no b_ack; after release a pending A and B tie resolves to A.
- miss_cnt at all-ones (CW=4, value 15) plus another read miss -> stays 15; cnt_clr in the same cycle as a miss -> 0.
